// File: rtl/nyakuo_mem_arbiter_if.sv
// Bundle of the fetch, load/store and external memory bus signals around nyakuo_mem_arbiter.
// master: the arbiter itself (it masters the memory bus).
// slave:  the surrounding fetch stage, LSU and memory.
interface nyakuo_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic              ls_unsigned;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [31:0]       ls_rdata;
    logic              ls_misalign;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              err;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata, ls_misalign,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output err
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_size, ls_unsigned, ls_addr, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_misalign,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  err
    );
endinterface

// File: rtl/nyakuo_mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit.
// One transaction at a time, round-robin under contention, byte-lane steering
// for stores and lane extraction / sign extension for loads.
// Optional macro NYAKUO_MEM_TIMEOUT_EN: abort a transaction after TIMEOUT
// ack-less bus cycles and flag it with err.
//
// state | meaning
// IDLE  | no transaction; grants may be given this cycle
// BUSY  | mem_req held, waiting for mem_ack
// DONE  | owner's rvalid pulses; back to IDLE next cycle
module nyakuo_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nyakuo_mem_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic              last_ls;
    logic              owner_ls;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic              req_q, we_q;
    logic [3:0]        be_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              if_rvalid_q, ls_rvalid_q, misalign_q;
    logic [31:0]       if_rdata_q, ls_rdata_q;

    logic              pick_ls, pick_if;
    logic              ls_misaligned;
    logic [3:0]        ls_be;
    logic [31:0]       ls_wd;
    logic [31:0]       load_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic              timed_out;

    // Arbitration: LS wins ties unless it won the previous grant.
    always_comb begin
        pick_ls = 1'b0;
        pick_if = 1'b0;
        if (state == S_IDLE) begin
            if (bus.ls_req && (!bus.if_req || !last_ls))
                pick_ls = 1'b1;
            else if (bus.if_req)
                pick_if = 1'b1;
        end
    end

    // Store lane steering and alignment check for the pending LS request.
    always_comb begin
        ls_misaligned = ((bus.ls_size == 2'b01) && bus.ls_addr[0]) ||
                        (bus.ls_size[1] && (bus.ls_addr[1:0] != 2'b00));
        case (bus.ls_size)
            2'b00: begin
                ls_be = 4'b0001 << bus.ls_addr[1:0];
                ls_wd = {4{bus.ls_wdata[7:0]}};
            end
            2'b01: begin
                ls_be = 4'b0011 << {bus.ls_addr[1], 1'b0};
                ls_wd = {2{bus.ls_wdata[15:0]}};
            end
            default: begin
                ls_be = 4'b1111;
                ls_wd = bus.ls_wdata;
            end
        endcase
    end

    // Load lane extraction from the bus word using the latched offset/size.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   load_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: load_data = bus.mem_rdata;
        endcase
    end

`ifdef NYAKUO_MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Terminal count reached with no ack in this BUSY cycle: abort.
    assign timed_out = (state == S_BUSY) && !bus.mem_ack && (tmo_cnt == '0);

    // Down-counter of ack-less BUSY cycles, reloaded at every grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= timed_out;
            if (pick_ls || pick_if)
                tmo_cnt <= TW'(TIMEOUT - 1);
            else if ((state == S_BUSY) && !bus.mem_ack && (tmo_cnt != '0))
                tmo_cnt <= tmo_cnt - 1'b1;
        end
    end
    assign bus.err = err_q;
`else
    assign timed_out = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // Transaction sequencer: latch on grant, hold the bus until ack, pulse completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_ls     <= 1'b0;
            owner_ls    <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            be_q        <= 4'b0000;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            misalign_q  <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            misalign_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_ls) begin
                        last_ls  <= 1'b1;
                        owner_ls <= 1'b1;
                        size_q   <= bus.ls_size;
                        uns_q    <= bus.ls_unsigned;
                        off_q    <= bus.ls_addr[1:0];
                        if (ls_misaligned) begin
                            // Never reaches the bus; report straight away.
                            state       <= S_DONE;
                            ls_rvalid_q <= 1'b1;
                            misalign_q  <= 1'b1;
                            ls_rdata_q  <= '0;
                        end else begin
                            state   <= S_BUSY;
                            req_q   <= 1'b1;
                            we_q    <= bus.ls_we;
                            be_q    <= ls_be;
                            addr_q  <= bus.ls_addr & ~ADDR_W'(3);
                            wdata_q <= ls_wd;
                        end
                    end else if (pick_if) begin
                        last_ls  <= 1'b0;
                        owner_ls <= 1'b0;
                        state    <= S_BUSY;
                        req_q    <= 1'b1;
                        we_q     <= 1'b0;
                        be_q     <= 4'b1111;
                        addr_q   <= bus.if_addr & ~ADDR_W'(3);
                        wdata_q  <= '0;
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ack || timed_out) begin
                        state <= S_DONE;
                        req_q <= 1'b0;
                        if (owner_ls) begin
                            ls_rvalid_q <= 1'b1;
                            ls_rdata_q  <= (bus.mem_ack && !we_q) ? load_data : '0;
                        end else begin
                            if_rvalid_q <= 1'b1;
                            if_rdata_q  <= bus.mem_ack ? bus.mem_rdata : '0;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.if_gnt      = pick_if;
    assign bus.ls_gnt      = pick_ls;
    assign bus.if_rvalid   = if_rvalid_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.ls_rvalid   = ls_rvalid_q;
    assign bus.ls_rdata    = ls_rdata_q;
    assign bus.ls_misalign = misalign_q;
    assign bus.mem_req     = req_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_be      = be_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
endmodule
